// File: rtl/radix16_bank_writer.sv
// Write-back packer for the radix-16 butterfly: a 2-deep group FIFO feeding registered
// bank writes, with read/write bank-conflict stalling and a frame-boundary pulse.
module radix16_bank_writer #(
    parameter int P_WIDTH      = 64,
    parameter int SD_WIDTH     = 128,
    parameter int ADDR_WIDTH   = 5,
    parameter int FRAME_GROUPS = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_bn_sel,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [P_WIDTH-1:0]    RA0_in,
    input  logic [P_WIDTH-1:0]    RA1_in,
    input  logic [P_WIDTH-1:0]    RA2_in,
    input  logic [P_WIDTH-1:0]    RA3_in,
    input  logic [P_WIDTH-1:0]    RA4_in,
    input  logic [P_WIDTH-1:0]    RA5_in,
    input  logic [P_WIDTH-1:0]    RA6_in,
    input  logic [P_WIDTH-1:0]    RA7_in,
    input  logic [P_WIDTH-1:0]    RA8_in,
    input  logic [P_WIDTH-1:0]    RA9_in,
    input  logic [P_WIDTH-1:0]    RA10_in,
    input  logic [P_WIDTH-1:0]    RA11_in,
    input  logic [P_WIDTH-1:0]    RA12_in,
    input  logic [P_WIDTH-1:0]    RA13_in,
    input  logic [P_WIDTH-1:0]    RA14_in,
    input  logic [P_WIDTH-1:0]    RA15_in,
    input  logic                  rd_active,
    input  logic                  rd_bn_sel,
    output logic [SD_WIDTH-1:0]   MEM0_out,
    output logic [SD_WIDTH-1:0]   MEM1_out,
    output logic [SD_WIDTH-1:0]   MEM2_out,
    output logic [SD_WIDTH-1:0]   MEM3_out,
    output logic [SD_WIDTH-1:0]   MEM4_out,
    output logic [SD_WIDTH-1:0]   MEM5_out,
    output logic [SD_WIDTH-1:0]   MEM6_out,
    output logic [SD_WIDTH-1:0]   MEM7_out,
    output logic                  BN0_wen,
    output logic                  BN1_wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  frame_done
);

    localparam int          GW         = 16 * P_WIDTH;
    localparam logic [15:0] FRAME_LAST = 16'(FRAME_GROUPS - 1);

    // RA0 sits in the top bits so each SD_WIDTH slice is {RA(2k), RA(2k+1)}
    logic [GW-1:0] in_group_s;
    assign in_group_s = {RA0_in, RA1_in, RA2_in, RA3_in, RA4_in, RA5_in, RA6_in, RA7_in,
                         RA8_in, RA9_in, RA10_in, RA11_in, RA12_in, RA13_in, RA14_in, RA15_in};

    logic [GW-1:0]         fifo_data_r [2];
    logic [ADDR_WIDTH-1:0] fifo_addr_r [2];
    logic [1:0]            fifo_bn_r;
    logic                  wr_ptr_r;
    logic                  rd_ptr_r;
    logic [1:0]            count_r;
    logic [15:0]           frame_cnt_r;

    logic                  in_ready_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  head_bn_s;

    logic                  bn0_wen_r;
    logic                  bn1_wen_r;
    logic                  frame_done_r;
    logic [ADDR_WIDTH-1:0] waddr_r;
    logic [GW-1:0]         data_r;

    // Handshake and pop decision; a head whose bank is being read blocks the whole queue
    always_comb begin
        in_ready_s = 1'b0;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        head_bn_s  = fifo_bn_r[rd_ptr_r];
        if (clear) begin
            in_ready_s = 1'b0;
            push_s     = 1'b0;
            pop_s      = 1'b0;
        end else begin
            in_ready_s = (count_r < 2'd2);
            push_s     = in_valid && in_ready_s;
            pop_s      = (count_r != 2'd0) && !(rd_active && (rd_bn_sel == head_bn_s));
        end
    end

    assign in_ready = in_ready_s;

    // FIFO payload storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_r[i] <= '0;
                fifo_addr_r[i] <= '0;
            end
            fifo_bn_r <= 2'b00;
        end else if (push_s) begin
            fifo_data_r[wr_ptr_r] <= in_group_s;
            fifo_addr_r[wr_ptr_r] <= in_addr;
            fifo_bn_r[wr_ptr_r]   <= in_bn_sel;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (clear) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame counter, advanced once per issued write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= 16'd0;
        end else if (clear) begin
            frame_cnt_r <= 16'd0;
        end else if (pop_s) begin
            if (frame_cnt_r == FRAME_LAST) begin
                frame_cnt_r <= 16'd0;
            end else begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
        end
    end

    // Registered write port; address and data hold between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bn0_wen_r    <= 1'b0;
            bn1_wen_r    <= 1'b0;
            frame_done_r <= 1'b0;
            waddr_r      <= '0;
            data_r       <= '0;
        end else begin
            bn0_wen_r    <= pop_s && !head_bn_s;
            bn1_wen_r    <= pop_s && head_bn_s;
            frame_done_r <= pop_s && (frame_cnt_r == FRAME_LAST);
            if (pop_s) begin
                waddr_r <= fifo_addr_r[rd_ptr_r];
                data_r  <= fifo_data_r[rd_ptr_r];
            end
        end
    end

    assign BN0_wen    = bn0_wen_r;
    assign BN1_wen    = bn1_wen_r;
    assign frame_done = frame_done_r;
    assign waddr      = waddr_r;
    assign MEM0_out   = data_r[GW-1                -: SD_WIDTH];
    assign MEM1_out   = data_r[GW-1 - 1 * SD_WIDTH -: SD_WIDTH];
    assign MEM2_out   = data_r[GW-1 - 2 * SD_WIDTH -: SD_WIDTH];
    assign MEM3_out   = data_r[GW-1 - 3 * SD_WIDTH -: SD_WIDTH];
    assign MEM4_out   = data_r[GW-1 - 4 * SD_WIDTH -: SD_WIDTH];
    assign MEM5_out   = data_r[GW-1 - 5 * SD_WIDTH -: SD_WIDTH];
    assign MEM6_out   = data_r[GW-1 - 6 * SD_WIDTH -: SD_WIDTH];
    assign MEM7_out   = data_r[GW-1 - 7 * SD_WIDTH -: SD_WIDTH];

endmodule

// File: tb/tb_radix16_bank_writer.sv
// Self-checking bench for radix16_bank_writer: vector table plus multi-cycle sequences,
// with a write scoreboard fed at every accepted push.
module tb_radix16_bank_writer;

    localparam int PW = 64;
    localparam int SW = 128;
    localparam int AW = 5;
    localparam int FG = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_bn_sel = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic          rd_active = 1'b0;
    logic          rd_bn_sel = 1'b0;
    logic [PW-1:0] ra [16];
    logic          in_ready;
    logic [SW-1:0] mem_o [8];
    logic          BN0_wen;
    logic          BN1_wen;
    logic [AW-1:0] waddr;
    logic          frame_done;

    always #5 clk = ~clk;

    radix16_bank_writer #(.P_WIDTH(PW), .SD_WIDTH(SW), .ADDR_WIDTH(AW), .FRAME_GROUPS(FG)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_bn_sel(in_bn_sel), .in_addr(in_addr),
        .RA0_in(ra[0]), .RA1_in(ra[1]), .RA2_in(ra[2]), .RA3_in(ra[3]),
        .RA4_in(ra[4]), .RA5_in(ra[5]), .RA6_in(ra[6]), .RA7_in(ra[7]),
        .RA8_in(ra[8]), .RA9_in(ra[9]), .RA10_in(ra[10]), .RA11_in(ra[11]),
        .RA12_in(ra[12]), .RA13_in(ra[13]), .RA14_in(ra[14]), .RA15_in(ra[15]),
        .rd_active(rd_active), .rd_bn_sel(rd_bn_sel),
        .MEM0_out(mem_o[0]), .MEM1_out(mem_o[1]), .MEM2_out(mem_o[2]), .MEM3_out(mem_o[3]),
        .MEM4_out(mem_o[4]), .MEM5_out(mem_o[5]), .MEM6_out(mem_o[6]), .MEM7_out(mem_o[7]),
        .BN0_wen(BN0_wen), .BN1_wen(BN1_wen), .waddr(waddr), .frame_done(frame_done)
    );

    typedef struct {
        logic          bn;
        logic [AW-1:0] addr;
        logic [1023:0] data;
        logic          fd;
    } exp_t;

    typedef struct {
        logic          bn;
        logic [AW-1:0] addr;
        logic [PW-1:0] base;
        logic          exp_wen0;
        logic          exp_wen1;
        logic [AW-1:0] exp_waddr;
        logic [SW-1:0] exp_mem0;
        logic [SW-1:0] exp_mem7;
    } vec_t;

    exp_t exp_q [$];
    exp_t mon_e;
    int   wr_cyc_q [$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   model_cnt = 0;
    int   wr_count = 0;
    int   fd_count = 0;
    int   cyc = 0;

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [1023:0] pack(input logic [PW-1:0] base);
        logic [1023:0] d;
        for (int i = 0; i < 16; i++) d[(15 - i) * PW +: PW] = base + 64'(i);
        return d;
    endfunction

    // Offers one group until accepted; the expected write is queued at the accepting edge
    task automatic send(input logic bn, input logic [AW-1:0] addr, input logic [PW-1:0] base,
                        input int max_wait);
        bit   ok;
        exp_t e;
        ok        = 1'b0;
        in_valid  = 1'b1;
        in_bn_sel = bn;
        in_addr   = addr;
        for (int i = 0; i < 16; i++) ra[i] = base + 64'(i);
        for (int c = 0; c < max_wait && !ok; c++) begin
            @(negedge clk);
            if (in_ready) begin
                e.bn = bn; e.addr = addr; e.data = pack(base); e.fd = (model_cnt == FG - 1);
                model_cnt = (model_cnt + 1) % FG;
                exp_q.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        check("accept_in_time", 128'(ok), 128'(1));
        in_valid = 1'b0;
    endtask

    task automatic wait_writes(input int target, input int max_cyc, input string name);
        int c;
        c = 0;
        while (wr_count < target && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        @(posedge clk); #1;
        check(name, 128'(wr_count >= target), 128'(1));
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        @(negedge clk);
        check("ready_low_in_clear", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        clear = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        @(negedge clk);
        check("ready_after_clear", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
    endtask

    // Write monitor / scoreboard
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            check("one_bank_only", 128'(BN0_wen && BN1_wen), 128'(0));
            if (BN0_wen || BN1_wen) begin
                wr_count++;
                wr_cyc_q.push_back(cyc);
                if (frame_done) fd_count++;
                check("sb_write_expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("sb_bank1", 128'(BN1_wen), 128'(mon_e.bn));
                    check("sb_waddr", 128'(waddr), 128'(mon_e.addr));
                    check("sb_frame_done", 128'(frame_done), 128'(mon_e.fd));
                    for (int k = 0; k < 8; k++)
                        check("sb_mem", mem_o[k], mon_e.data[(7 - k) * SW +: SW]);
                end
            end else begin
                check("idle_frame_done", 128'(frame_done), 128'(0));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        vec_t vecs [4];
        int   base_wr;
        int   base_fd;
        vecs[0] = '{1'b0, 5'd5, 64'd1, 1'b1, 1'b0, 5'd5,
                    128'h0000000000000001_0000000000000002, 128'h000000000000000F_0000000000000010};
        vecs[1] = '{1'b1, 5'd31, 64'hFFFFFFFFFFFFFFF0, 1'b0, 1'b1, 5'd31,
                    128'hFFFFFFFFFFFFFFF0_FFFFFFFFFFFFFFF1, 128'hFFFFFFFFFFFFFFFE_FFFFFFFFFFFFFFFF};
        vecs[2] = '{1'b0, 5'd0, 64'hA5A5000000000000, 1'b1, 1'b0, 5'd0,
                    128'hA5A5000000000000_A5A5000000000001, 128'hA5A500000000000E_A5A500000000000F};
        vecs[3] = '{1'b1, 5'd10, 64'h0123456789ABCDE0, 1'b0, 1'b1, 5'd10,
                    128'h0123456789ABCDE0_0123456789ABCDE1, 128'h0123456789ABCDEE_0123456789ABCDEF};
        for (int i = 0; i < 16; i++) ra[i] = '0;

        // Reset state
        #12;
        check("rst_bn0_wen", 128'(BN0_wen), 128'(0));
        check("rst_bn1_wen", 128'(BN1_wen), 128'(0));
        check("rst_frame_done", 128'(frame_done), 128'(0));
        check("rst_waddr", 128'(waddr), 128'(0));
        for (int k = 0; k < 8; k++) check("rst_mem", mem_o[k], 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;

        // Vector table: push, nothing at N+1, write at N+2
        for (int v = 0; v < 4; v++) begin
            send(vecs[v].bn, vecs[v].addr, vecs[v].base, 4);
            @(negedge clk);
            check("vec_no_early_wen", 128'({BN0_wen, BN1_wen}), 128'(0));
            @(negedge clk);
            check("vec_bn0_wen", 128'(BN0_wen), 128'(vecs[v].exp_wen0));
            check("vec_bn1_wen", 128'(BN1_wen), 128'(vecs[v].exp_wen1));
            check("vec_waddr", 128'(waddr), 128'(vecs[v].exp_waddr));
            check("vec_mem0", mem_o[0], vecs[v].exp_mem0);
            check("vec_mem7", mem_o[7], vecs[v].exp_mem7);
            @(posedge clk); #1;
        end

        // Backpressure: bank 0 under read, FIFO fills, then drains back-to-back
        rd_active = 1'b1;
        rd_bn_sel = 1'b0;
        base_wr = wr_count;
        send(1'b0, 5'd0, 64'd100, 4);
        send(1'b0, 5'd1, 64'd200, 4);
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_ready_low", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_no_write", 128'(wr_count), 128'(base_wr));
        fork
            begin
                repeat (3) @(posedge clk);
                #1 rd_active = 1'b0;
            end
        join_none
        send(1'b0, 5'd2, 64'd300, 12);
        wait_writes(base_wr + 3, 10, "bp_drain_timeout");
        check("bp_consecutive_1", 128'(wr_cyc_q[$-1] - wr_cyc_q[$-2]), 128'(1));
        check("bp_consecutive_2", 128'(wr_cyc_q[$] - wr_cyc_q[$-1]), 128'(1));

        // Bank conflict: BN1 read does not stall a BN0 write, but stalls a BN1 write
        rd_active = 1'b1;
        rd_bn_sel = 1'b1;
        send(1'b0, 5'd3, 64'd400, 4);
        @(negedge clk);
        check("bc_no_early_wen", 128'({BN0_wen, BN1_wen}), 128'(0));
        @(negedge clk);
        check("bc_bn0_wen", 128'(BN0_wen), 128'(1));
        @(posedge clk); #1;
        base_wr = wr_count;
        send(1'b1, 5'd4, 64'd500, 4);
        repeat (5) @(posedge clk);
        #1;
        check("bc_bn1_stalled", 128'(wr_count), 128'(base_wr));
        rd_active = 1'b0;
        wait_writes(base_wr + 1, 6, "bc_release_timeout");

        // Frame: fresh counter, 5 back-to-back groups, one pulse
        clear_pulse();
        base_wr = wr_count;
        base_fd = fd_count;
        for (int i = 0; i < 5; i++) send(1'b0, 5'(i), 64'(600 + i * 16), 4);
        wait_writes(base_wr + 5, 6, "frame_timeout");
        check("frame_pulse_count", 128'(fd_count - base_fd), 128'(1));
        check("frame_throughput", 128'(wr_cyc_q[$] - wr_cyc_q[$-4]), 128'(4));

        // Clear with two blocked groups: nothing written, counter restarts
        rd_active = 1'b1;
        rd_bn_sel = 1'b0;
        send(1'b0, 5'd7, 64'd700, 4);
        send(1'b0, 5'd8, 64'd800, 4);
        base_wr = wr_count;
        clear_pulse();
        rd_active = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("clr_no_write", 128'(wr_count), 128'(base_wr));
        base_fd = fd_count;
        for (int i = 0; i < 3; i++) send(1'b1, 5'(12 + i), 64'(900 + i * 16), 4);
        wait_writes(base_wr + 3, 6, "clr_fresh_timeout");
        check("clr_no_early_pulse", 128'(fd_count), 128'(base_fd));
        send(1'b1, 5'd15, 64'd1000, 4);
        wait_writes(base_wr + 4, 6, "clr_fourth_timeout");
        check("clr_pulse_after_four", 128'(fd_count - base_fd), 128'(1));

        // Reset mid-stream while a write is on the outputs
        send(1'b0, 5'd9, 64'h0000_0000_0000_1100, 4);
        send(1'b1, 5'd10, 64'h0000_0000_0000_2200, 4);
        check("rst_mid_pre_wen", 128'(BN0_wen), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_bn0_wen", 128'(BN0_wen), 128'(0));
        check("rst_mid_bn1_wen", 128'(BN1_wen), 128'(0));
        check("rst_mid_frame_done", 128'(frame_done), 128'(0));
        check("rst_mid_waddr", 128'(waddr), 128'(0));
        for (int k = 0; k < 8; k++) check("rst_mid_mem", mem_o[k], 128'(0));
        exp_q.delete();
        model_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        base_wr = wr_count;
        @(negedge clk);
        check("rst_mid_in_ready", 128'(in_ready), 128'(1));
        repeat (5) @(posedge clk);
        #1;
        check("rst_mid_no_stale", 128'(wr_count), 128'(base_wr));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
